// File: rtl/hint_bit_codec.sv
// Hint bit codec: packs K x 256 hint bits into an omega-indexed byte string
// and unpacks/validates such a byte string back into hint bits.
module hint_bit_codec #(
  parameter int K = 8,
  parameter int W = 75
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startpin,
  input  logic                 mode,
  input  logic [K*256-1:0]     h_in,
  input  logic [(W+K)*8-1:0]   y_in,
  output logic [(W+K)*8-1:0]   y,
  output logic [K*256-1:0]     h,
  output logic                 endpin,
  output logic                 err,
  output logic                 busy
);

  localparam int IW = $clog2(W+1);
  localparam int CW = $clog2(K)+1;
  localparam int BW = $clog2(W+K);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PACK        = 3'd1,
    UNPACK_HDR  = 3'd2,
    UNPACK_IDX  = 3'd3,
    UNPACK_ZERO = 3'd4,
    DONE        = 3'd5
  } state_t;

  state_t               state_r;
  logic [IW-1:0]        index_r;
  logic [IW-1:0]        first_r;
  logic [CW-1:0]        i_r;
  logic [8:0]           j_r;
  logic [(W+K)*8-1:0]   y_r;
  logic [K*256-1:0]     h_r;
  logic                 endpin_r;
  logic                 err_r;
  logic                 busy_r;

  logic [BW-1:0]        cur_bi_s;
  logic [BW-1:0]        prev_bi_s;
  logic [BW-1:0]        hdr_bi_s;
  logic [7:0]           cur_byte_s;
  logic [7:0]           prev_byte_s;
  logic [7:0]           limit_s;
  logic [7:0]           idx8_s;
  logic [CW+6:0]        hbit_s;
  logic [CW+6:0]        pbit_s;
  logic                 hin_bit_s;

  assign y      = y_r;
  assign h      = h_r;
  assign endpin = endpin_r;
  assign err    = err_r;
  assign busy   = busy_r;

  // Byte/bit addressing derived from the current index, polynomial and coefficient
  always_comb begin
    cur_bi_s    = BW'(index_r);
    prev_bi_s   = BW'(index_r - IW'(1'b1));
    hdr_bi_s    = BW'(W) + BW'(i_r);
    cur_byte_s  = y_in[{cur_bi_s, 3'b000} +: 8];
    prev_byte_s = y_in[{prev_bi_s, 3'b000} +: 8];
    limit_s     = y_in[{hdr_bi_s, 3'b000} +: 8];
    idx8_s      = 8'(index_r);
    hbit_s      = {i_r[CW-2:0], cur_byte_s};
    pbit_s      = {i_r[CW-2:0], j_r[7:0]};
    hin_bit_s   = h_in[pbit_s];
  end

  // Control FSM with registered results and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      index_r  <= '0;
      first_r  <= '0;
      i_r      <= '0;
      j_r      <= 9'd0;
      y_r      <= '0;
      h_r      <= '0;
      endpin_r <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (startpin) begin
            y_r      <= '0;
            h_r      <= '0;
            index_r  <= '0;
            first_r  <= '0;
            i_r      <= '0;
            j_r      <= 9'd0;
            err_r    <= 1'b0;
            endpin_r <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= mode ? UNPACK_HDR : PACK;
          end
        end
        PACK: begin
          // coefficient slot 256 is the per-polynomial cumulative count write
          if (j_r == 9'd256) begin
            y_r[{hdr_bi_s, 3'b000} +: 8] <= idx8_s;
            j_r <= 9'd0;
            i_r <= i_r + CW'(1'b1);
            if (i_r == CW'(K-1)) begin
              state_r  <= DONE;
              endpin_r <= 1'b1;
              busy_r   <= 1'b0;
            end
          end else begin
            if (hin_bit_s) begin
              if (index_r < IW'(W)) begin
                y_r[{cur_bi_s, 3'b000} +: 8] <= j_r[7:0];
                index_r <= index_r + IW'(1'b1);
              end else begin
                err_r <= 1'b1;
              end
            end
            j_r <= j_r + 9'd1;
          end
        end
        UNPACK_HDR: begin
          if (i_r == CW'(K)) begin
            state_r <= UNPACK_ZERO;
          end else if ((limit_s < idx8_s) || (limit_s > 8'(W))) begin
            err_r    <= 1'b1;
            state_r  <= DONE;
            endpin_r <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            first_r <= index_r;
            state_r <= UNPACK_IDX;
          end
        end
        UNPACK_IDX: begin
          if (idx8_s == limit_s) begin
            i_r     <= i_r + CW'(1'b1);
            state_r <= UNPACK_HDR;
          end else if ((index_r > first_r) && (prev_byte_s >= cur_byte_s)) begin
            err_r    <= 1'b1;
            state_r  <= DONE;
            endpin_r <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            h_r[hbit_s] <= 1'b1;
            index_r     <= index_r + IW'(1'b1);
          end
        end
        UNPACK_ZERO: begin
          if (index_r == IW'(W)) begin
            state_r  <= DONE;
            endpin_r <= 1'b1;
            busy_r   <= 1'b0;
          end else if (cur_byte_s != 8'd0) begin
            err_r    <= 1'b1;
            state_r  <= DONE;
            endpin_r <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            index_r <= index_r + IW'(1'b1);
          end
        end
        DONE: begin
          if (!startpin) begin
            state_r  <= IDLE;
            endpin_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          endpin_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hint_bit_codec.md
HINT_BIT_CODEC -- requirements
Module: hint_bit_codec

Interface
REQ-001 SHALL have parameter K, default 8, meaning the number of hint polynomials (4, 6 or 8).
REQ-002 SHALL have parameter W, default 75, meaning the omega index budget (80, 55 or 75).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port startpin, input, 1 bit, the operation request, sampled in IDLE only.
REQ-006 SHALL have port mode, input, 1 bit: 0 selects pack, 1 selects unpack; it is sampled with startpin.
REQ-007 SHALL have port h_in, input, K x 256 bits, the hint bits for pack.
REQ-008 SHALL have port y_in, input, (W+K) x 8 bits, the encoded bytes for unpack.
REQ-009 SHALL have port y, output, (W+K) x 8 bits, the pack result.
REQ-010 SHALL have port h, output, K x 256 bits, the unpack result.
REQ-011 SHALL have port endpin, output, 1 bit, the operation-complete flag.
REQ-012 SHALL have port err, output, 1 bit: malformed input (unpack) or omega overflow (pack).
REQ-013 SHALL have port busy, output, 1 bit, high in every state other than IDLE and DONE.

Function
REQ-014 SHALL implement the states IDLE, PACK, UNPACK_HDR, UNPACK_IDX, UNPACK_ZERO and DONE.
REQ-015 In IDLE with startpin=1, SHALL clear y, h, index, i, j, err and endpin, then enter PACK if mode=0 or UNPACK_HDR if mode=1.
REQ-016 h_in, y_in and mode SHALL be held stable by the requester while busy; the block SHALL NOT register copies of them.
REQ-017 PACK SHALL scan one coefficient per cycle, j = 0..255, and spend one extra cycle per polynomial writing y[W+i] = index, giving exactly K*257 PACK cycles.
REQ-018 PACK, on h_in[i][j]=1 with index<W, SHALL write y[index]=j[7:0] and increment index.
REQ-019 PACK, on h_in[i][j]=1 with index=W, SHALL set err, suppress the write, and continue the scan; y[W+i] SHALL still record the saturated index.
REQ-020 PACK, on the edge where i reaches K, SHALL enter DONE and set endpin on that same edge; latency from the startpin edge to endpin high SHALL be K*257+1 edges.
REQ-021 UNPACK_HDR for polynomial i SHALL check the limit = y_in[W+i].
REQ-022 UNPACK_HDR SHALL set err and enter DONE if limit < index or limit > W.
REQ-023 UNPACK_HDR SHALL otherwise record first=index and go to UNPACK_IDX; if i=K instead, it SHALL go to UNPACK_ZERO.
REQ-024 UNPACK_IDX SHALL consume one byte per cycle while index < limit.
REQ-025 UNPACK_IDX SHALL set err and enter DONE if index > first and y_in[index-1] >= y_in[index] (non-ascending order).
REQ-026 UNPACK_IDX SHALL otherwise set h[i][y_in[index]]=1 and increment index.
REQ-027 UNPACK_IDX, when index = limit, SHALL increment i and return to UNPACK_HDR.
REQ-028 UNPACK_ZERO SHALL check y_in[index..W-1] one byte per cycle, setting err and entering DONE on any nonzero byte.
REQ-029 UNPACK_ZERO SHALL enter DONE once index = W.
REQ-030 Unpack latency SHALL NOT exceed 2K + 2W + 2 edges from the startpin edge to endpin high.
REQ-031 On err in unpack, h SHALL be left partially written and is invalid; consumers SHALL qualify h with err=0.
REQ-032 DONE SHALL hold endpin=1 and err; when startpin=0 it SHALL return to IDLE on the next edge and clear endpin; y, h and err SHALL persist until the next start.
REQ-033 index SHALL be $clog2(W+1) bits wide, i SHALL be $clog2(K)+1 bits wide, and j SHALL be 9 bits wide; all comparisons SHALL be unsigned.
REQ-034 startpin asserted in any state other than IDLE and DONE SHALL be ignored.

Reset
REQ-035 rst=1 SHALL asynchronously force state=IDLE, y=0, h=0, index=0, i=0, j=0, endpin=0, err=0 and busy=0, including mid-operation; operation SHALL resume only on a new startpin after rst deasserts.

Verification
REQ-036 K=4, W=80, pack, h_in[0][3]=h_in[0][200]=1, h_in[2][7]=1 -> y[0..2]=3,200,7; y[80..83]=2,2,3,3; err=0; endpin high after 1029 edges.
REQ-037 K=4, W=80, pack with 81 ones spread over all polynomials -> err=1; y[0..79] holds the first 80 indices; y[83]=80.
REQ-038 K=4, W=80, unpack of the REQ-036 output -> h equals that h_in; err=0.
REQ-039 Unpack malformed cases, each -> err=1, endpin=1 and early DONE: y_in[80]=5, y_in[81]=3 (decreasing count); y_in[0..1]=9,9 (non-ascending); nonzero padding byte y_in[79]=1 with count 3.
REQ-040 rst pulsed mid-PACK at cycle 300 -> all outputs zero immediately; a fresh start then reproduces REQ-036 exactly.
REQ-041 startpin held high through DONE -> endpin stays 1 with no restart; dropping startpin -> IDLE next edge, endpin=0.
